// File: rtl/seg_frame_sched_pkg.sv
// Shared types and constants for the seven-segment frame scheduler.
//   state_e   : scheduler FSM states
//   SEG_TABLE : active-low {dp,g,f,e,d,c,b,a} codes for hex nibbles 0..F
//   frame_t   : 32-bit frame sent to the serial shifter
package seg_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned NIB_W   = 4;
  localparam int unsigned SEG_W   = 8;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned CNT_W   = 32;
  localparam int unsigned RSVD_W  = 14;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_FIN,
    S_ACK,
    S_DWELL
  } state_e;

  // Entry n holds the code for nibble n (entry 15 is written first).
  localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;

  // Field layout, MSB first: [31:24] seg, [23:16] sel, [15] carry, [14] ovf, [13:0] zero.
  typedef struct packed {
    logic [SEG_W-1:0]  seg;
    logic [SEG_W-1:0]  sel;
    logic              carry;
    logic              ovf;
    logic [RSVD_W-1:0] rsvd;
  } frame_t;

  localparam frame_t FRAME_RST = '{seg: 8'hFF, sel: 8'hFF, carry: 1'b0, ovf: 1'b0, rsvd: '0};

endpackage

// File: rtl/seg_frame_sched_hex_to_seg7.sv
// Hex nibble to active-low seven-segment code, with forced blanking.
//   i_nib   : nibble to display
//   i_blank : 1 drives all segments off
//   o_seg_c : combinational active-low segment code
module hex_to_seg7
  import seg_pkg::*;
(
  input  logic [NIB_W-1:0] i_nib,
  input  logic             i_blank,
  output logic [SEG_W-1:0] o_seg_c
);

  always_comb o_seg_c = i_blank ? SEG_BLANK : SEG_TABLE[i_nib];

endmodule

// File: rtl/seg_frame_sched.sv
// Scans a latched 32-bit value plus carry/ovf as 8 hex digits, one frame per
// digit, through the serial shifter start/busy/finish/ack handshake.
//   clk, rst_n       : clock, async active-low reset
//   en               : scanning enable (current frame always completes)
//   load/value/carry/ovf : capture into the pending register set
//   tx_start/tx_data : frame request to the shifter
//   tx_busy/tx_finish: shifter status
//   tx_ack           : one-cycle finish acknowledge
//   digit_idx        : digit currently framed
//   err              : sticky busy-timeout flag
module seg_frame_sched
  import seg_pkg::*;
#(
  parameter int unsigned DWELL      = 50000,
  parameter int unsigned START_HOLD = 4,
  parameter int unsigned TIMEOUT    = 1024,
  parameter int unsigned BLANK_LZ   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              load,
  input  logic [DATA_W-1:0] value,
  input  logic              carry,
  input  logic              ovf,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_busy,
  input  logic              tx_finish,
  output logic              tx_ack,
  output logic [IDX_W-1:0]  digit_idx,
  output logic              err
);

  state_e            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_tx_start, w_tx_start_nxt;
  logic              r_tx_ack, w_tx_ack_nxt;
  frame_t            r_tx_data, w_tx_data_nxt;
  logic [IDX_W-1:0]  r_digit_idx, w_digit_idx_nxt;
  logic              r_err, w_err_nxt;

  logic [DATA_W-1:0] r_pend_val, r_disp_val;
  logic              r_pend_c, r_pend_o, r_disp_c, r_disp_o;

  logic              w_copy;
  logic [DATA_W-1:0] w_src_val, w_shifted;
  logic              w_src_c, w_src_o, w_blank;
  logic [SEG_W-1:0]  w_seg;
  frame_t            w_frame;

  // The displayed set refreshes only at a digit-0 LOAD; a coincident load bypasses pending.
  assign w_copy    = (r_state == S_LOAD) && (r_digit_idx == '0);
  assign w_src_val = w_copy ? (load ? value : r_pend_val) : r_disp_val;
  assign w_src_c   = w_copy ? (load ? carry : r_pend_c) : r_disp_c;
  assign w_src_o   = w_copy ? (load ? ovf : r_pend_o) : r_disp_o;

  // Digit i is a leading zero when every nibble from i upward is zero.
  assign w_shifted = w_src_val >> {r_digit_idx, 2'b00};
  assign w_blank   = (BLANK_LZ != 0) && (r_digit_idx != '0) && (w_shifted == '0);

  hex_to_seg7 u_hex_to_seg7 (
    .i_nib   (w_shifted[NIB_W-1:0]),
    .i_blank (w_blank),
    .o_seg_c (w_seg)
  );

  always_comb begin
    w_frame       = FRAME_RST;
    w_frame.seg   = w_seg;
    w_frame.sel   = ~(SEG_W'(1) << r_digit_idx);
    w_frame.carry = w_src_c;
    w_frame.ovf   = w_src_o;
  end

  // Pending and displayed operand sets.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_val <= '0;
      r_pend_c   <= 1'b0;
      r_pend_o   <= 1'b0;
      r_disp_val <= '0;
      r_disp_c   <= 1'b0;
      r_disp_o   <= 1'b0;
    end else begin
      if (load) begin
        r_pend_val <= value;
        r_pend_c   <= carry;
        r_pend_o   <= ovf;
      end
      if (w_copy) begin
        r_disp_val <= w_src_val;
        r_disp_c   <= w_src_c;
        r_disp_o   <= w_src_o;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_tx_start  <= 1'b0;
      r_tx_ack    <= 1'b0;
      r_tx_data   <= FRAME_RST;
      r_digit_idx <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_tx_start  <= w_tx_start_nxt;
      r_tx_ack    <= w_tx_ack_nxt;
      r_tx_data   <= w_tx_data_nxt;
      r_digit_idx <= w_digit_idx_nxt;
      r_err       <= w_err_nxt;
    end
  end

  // Next state; r_cnt runs from start rise through WAIT_BUSY so the timeout covers the hold.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_tx_start_nxt  = r_tx_start;
    w_tx_ack_nxt    = 1'b0;
    w_tx_data_nxt   = r_tx_data;
    w_digit_idx_nxt = r_digit_idx;
    w_err_nxt       = r_err;
    case (r_state)
      S_IDLE: begin
        if (en) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_tx_data_nxt  = w_frame;
        w_tx_start_nxt = 1'b1;
        w_cnt_nxt      = '0;
        w_state_nxt    = S_START;
      end
      S_START: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(START_HOLD - 1)) w_state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (tx_busy) begin
          w_tx_start_nxt = 1'b0;
          w_state_nxt    = S_WAIT_FIN;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_err_nxt      = 1'b1;
          w_tx_start_nxt = 1'b0;
          w_cnt_nxt      = '0;
          w_state_nxt    = S_DWELL;
        end
      end
      S_WAIT_FIN: begin
        if (tx_finish) begin
          w_tx_ack_nxt = 1'b1;
          w_state_nxt  = S_ACK;
        end
      end
      S_ACK: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_DWELL;
      end
      S_DWELL: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(DWELL - 1)) begin
          w_cnt_nxt       = '0;
          w_digit_idx_nxt = r_digit_idx + IDX_W'(1);
          w_state_nxt     = en ? S_LOAD : S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign tx_start  = r_tx_start;
  assign tx_ack    = r_tx_ack;
  assign tx_data   = r_tx_data;
  assign digit_idx = r_digit_idx;
  assign err       = r_err;

endmodule

// File: tb/tb_seg_frame_sched.sv
// Directed bench for seg_frame_sched with a small shifter responder model.
module tb_seg_frame_sched;

  localparam int unsigned START_HOLD = 4;
  localparam int unsigned TIMEOUT    = 1024;
  localparam int unsigned WAIT_MAX   = 5000;

  logic        clk, rst_n, en, load, carry, ovf;
  logic [31:0] value, tx_data;
  logic        tx_start, tx_busy, tx_finish, tx_ack, err;
  logic [2:0]  digit_idx;

  // Hand-computed frames for value 32'h1234ABCD, carry=0, ovf=0.
  localparam logic [31:0] EXP_A [8] = '{
    32'hA1FE0000, 32'hC6FD0000, 32'h83FB0000, 32'h88F70000,
    32'h99EF0000, 32'hB0DF0000, 32'hA4BF0000, 32'hF97F0000
  };
  localparam logic [7:0] SEL [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

  seg_frame_sched #(
    .DWELL      (6),
    .START_HOLD (START_HOLD),
    .TIMEOUT    (TIMEOUT),
    .BLANK_LZ   (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .load      (load),
    .value     (value),
    .carry     (carry),
    .ovf       (ovf),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .tx_finish (tx_finish),
    .tx_ack    (tx_ack),
    .digit_idx (digit_idx),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shifter model: two-flop start edge detect, busy for 6 cycles, finish held until ack.
  logic       sh_en;
  logic [1:0] s_sync;
  int         bcnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_sync    <= 2'b00;
      tx_busy   <= 1'b0;
      tx_finish <= 1'b0;
      bcnt      <= 0;
    end else begin
      s_sync <= {s_sync[0], tx_start};
      if (sh_en && s_sync[0] && !s_sync[1]) begin
        tx_busy <= 1'b1;
        bcnt    <= 5;
      end else if (tx_busy) begin
        if (bcnt == 0) begin
          tx_busy   <= 1'b0;
          tx_finish <= 1'b1;
        end else begin
          bcnt <= bcnt - 1;
        end
      end
      if (tx_ack) tx_finish <= 1'b0;
    end
  end

  // Width of the most recent tx_start pulse.
  int run_w = 0, last_w = 0;
  always @(negedge clk) begin
    if (tx_start) run_w++;
    else if (run_w != 0) begin
      last_w = run_w;
      run_w  = 0;
    end
  end

  int n_vec = 0, n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Waits for the next tx_start rise, returns the framed data and digit.
  task automatic wait_frame(output logic [31:0] d, output logic [2:0] idx);
    int n = 0;
    while (tx_start && n < WAIT_MAX) begin @(negedge clk); n++; end
    while (!tx_start && n < WAIT_MAX) begin @(negedge clk); n++; end
    check("frame_wait_timeout", 32'(n >= WAIT_MAX), 32'd0);
    d   = tx_data;
    idx = digit_idx;
  endtask

  task automatic pulse_load(input logic [31:0] v, input logic c, input logic o);
    value = v; carry = c; ovf = o; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  logic [31:0] d;
  logic [2:0]  idx;

  initial begin
    rst_n = 1'b0; en = 1'b0; load = 1'b0; value = '0; carry = 1'b0; ovf = 1'b0; sh_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_ack", 32'(tx_ack), 32'd0);
    check("rst_tx_data", tx_data, 32'hFFFF0000);
    check("rst_digit_idx", 32'(digit_idx), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    pulse_load(32'h1234ABCD, 1'b0, 1'b0);
    en = 1'b1;

    // First frame, ack timing, start width (START_HOLD plus the cycle that sees busy).
    wait_frame(d, idx);
    check("f0_data", d, EXP_A[0]);
    check("f0_idx", 32'(idx), 32'd0);
    begin
      int n = 0;
      while (!tx_finish && n < WAIT_MAX) begin @(negedge clk); n++; end
      check("finish_wait_timeout", 32'(n >= WAIT_MAX), 32'd0);
    end
    check("ack_before", 32'(tx_ack), 32'd0);
    @(negedge clk);
    check("ack_pulse", 32'(tx_ack), 32'd1);
    check("ack_data_stable", tx_data, EXP_A[0]);
    @(negedge clk);
    check("ack_width", 32'(tx_ack), 32'd0);
    check("start_width", 32'(last_w), 32'(START_HOLD + 1));

    // Rest of the pass, then wrap to digit 0.
    for (int i = 1; i < 8; i++) begin
      wait_frame(d, idx);
      check("passA_data", d, EXP_A[i]);
      check("passA_idx", 32'(idx), 32'(i));
    end
    wait_frame(d, idx);
    check("wrap_data", d, EXP_A[0]);
    check("wrap_idx", 32'(idx), 32'd0);

    // Load during digit 3: remainder of the pass keeps the old value.
    for (int i = 1; i < 8; i++) begin
      wait_frame(d, idx);
      check("midload_data", d, EXP_A[i]);
      if (i == 3) pulse_load(32'h00000005, 1'b1, 1'b0);
    end

    // value=5, carry=1: digit 0 shows "5", the rest are blanked leading zeros.
    wait_frame(d, idx);
    check("v5_d0", d, 32'h92FE8000);
    for (int i = 1; i < 8; i++) begin
      wait_frame(d, idx);
      check("v5_blank", d, {8'hFF, SEL[i], 16'h8000});
      if (i == 1) pulse_load(32'h00000000, 1'b0, 1'b0);
    end

    // value=0: digit 0 still shows "0".
    wait_frame(d, idx);
    check("v0_d0", d, 32'hC0FE0000);

    // Busy never arrives on digit 1: start held TIMEOUT cycles, then err.
    wait_frame(d, idx);
    sh_en = 1'b0;
    check("v0_d1", d, 32'hFFFD0000);
    repeat (TIMEOUT - 1) @(negedge clk);
    check("to_start_held", 32'(tx_start), 32'd1);
    check("to_err_before", 32'(err), 32'd0);
    @(negedge clk);
    check("to_start_drop", 32'(tx_start), 32'd0);
    check("to_err_set", 32'(err), 32'd1);
    sh_en = 1'b1;
    wait_frame(d, idx);
    check("to_next_idx", 32'(idx), 32'd2);
    check("to_next_data", d, 32'hFFFB0000);

    // Reset while waiting for finish.
    begin
      int n = 0;
      while (!(tx_busy && !tx_start) && n < WAIT_MAX) begin @(negedge clk); n++; end
      check("waitfin_timeout", 32'(n >= WAIT_MAX), 32'd0);
    end
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx_start", 32'(tx_start), 32'd0);
    check("mid_rst_tx_ack", 32'(tx_ack), 32'd0);
    check("mid_rst_tx_data", tx_data, 32'hFFFF0000);
    check("mid_rst_idx", 32'(digit_idx), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
